sram_access_ctrl: RTL and testbench
===================================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning): ROW_BITS, 5, row address width; WL_CYCLES, 2, wordline-active cycles per access (1..15).
REQ-002 clk  in  1  single clock; all logic rising-edge triggered.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake.
REQ-005 req_we  in  1  1 = write, 0 = read.
REQ-006 req_conf  in  2  word width: 00 = 32b, 01 = 16b, 10 = 8b, 11 = illegal.
REQ-007 req_addr  in  ROW_BITS+2  [ROW_BITS+1:2] = row, [1:0] = sub-word select.
REQ-008 req_wdata  in  32  write data, right-aligned.
REQ-009 row_addr  out  ROW_BITS  row to the array decoder.
REQ-010 pre_en, wl_en, wr_en, sae  out  1 each  precharge, wordline, write driver, sense-amp enables.
REQ-011 mask_conf / mask_addr  out  2 / 2  drive the 8-of-32 bitline-mask decoder's conf/addr.
REQ-012 arr_wdata  out  32  lane-replicated write data; arr_rdata  in  32  sensed row data.
REQ-013 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-014 rsp_rdata  out  32  read result, zero-extended; rsp_err  out  1  illegal conf.

Function
REQ-015 States SHALL be IDLE, PRE, ACT, SENSE, RESP.
REQ-016 req_ready SHALL be 1 exactly in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-017 On acceptance the block SHALL register row, conf, sub-select, we and wdata; these registers SHALL hold unchanged until return to IDLE.
REQ-018 Legal conf SHALL go IDLE->PRE; conf 11 SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0, and no array enable asserted.
REQ-019 PRE SHALL last 1 cycle with pre_en=1, then go to ACT.
REQ-020 ACT SHALL last WL_CYCLES cycles (4-bit down-counter) with wl_en=1 and wr_en=we.
REQ-021 After ACT, writes SHALL go to RESP; reads SHALL go to SENSE.
REQ-022 SENSE SHALL last 1 cycle with wl_en=1, sae=1; arr_rdata is captured at the end of SENSE.
REQ-023 Read latency from the accept edge to the first rsp_valid cycle SHALL be WL_CYCLES+3 cycles; write latency WL_CYCLES+2; illegal-conf latency 1.
REQ-024 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then go to IDLE; no new request is accepted in the same cycle.
REQ-025 pre_en, wl_en, wr_en, sae SHALL be mutually exclusive except wl_en with wr_en (ACT) or wl_en with sae (SENSE).
REQ-026 mask_conf/mask_addr SHALL equal the registered conf/sub-select in PRE, ACT and SENSE, and 0 otherwise.
REQ-027 row_addr SHALL equal the registered row in PRE, ACT and SENSE, and 0 otherwise.
REQ-028 Lane map: conf 00 uses bits [31:0]; conf 01 uses half h=addr[0] at bits [16h+15:16h]; conf 10 uses byte b=addr[1:0] at bits [8b+7:8b]. Ignored sub-select bits SHALL be masked to 0 on mask_addr.
REQ-029 arr_wdata SHALL be wdata for conf 00, {wdata[15:0],wdata[15:0]} for 01, and {4{wdata[7:0]}} for 10; it is 0 when not in ACT.
REQ-030 Read rsp_rdata SHALL be the selected lane of captured arr_rdata, zero-extended; write responses SHALL return rsp_rdata=0, rsp_err=0.
REQ-031 Inputs changing while req_ready=0 SHALL have no effect.

Reset
REQ-032 rst_n=0 at a clk edge SHALL force IDLE and zero all outputs except req_ready, which is 1 only after reset deasserts.
REQ-033 Reset in any state SHALL drop the in-flight transaction with no response.
REQ-034 The WL counter and all captured registers SHALL reset to 0.

Verification
REQ-035 Read, conf 00, row 3, WL_CYCLES=2, arr_rdata=0xDEADBEEF -> PRE 1 cycle, wl_en 2 cycles, sae 1 cycle; rsp_rdata=0xDEADBEEF at cycle 5; mask_conf=00, mask_addr=00.
REQ-036 Write, conf 10, addr sub=2, wdata=0x000000A5 -> arr_wdata=0xA5A5A5A5 and wr_en=wl_en=1 for 2 cycles, mask_addr=10; response at cycle 4 with rsp_rdata=0.
REQ-037 Read, conf 01, sub=01, arr_rdata=0x1234ABCD -> rsp_rdata=0x00001234, mask_addr=01; repeat with sub=11 -> same, mask_addr=01.
REQ-038 conf 11 request -> rsp_valid next cycle with rsp_err=1; pre_en, wl_en, wr_en, sae never assert.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; IDLE follows the cycle after rsp_ready=1.
REQ-040 rst_n=0 during ACT -> next cycle all enables 0, req_ready=0, no rsp_valid; after release a new read completes normally.

Source files
------------

// File: rtl/sram_access_ctrl_if.sv
// Request/response bus between a requester and sram_access_ctrl.
//   master modport : the requester side (drives req_*, rsp_ready)
//   slave modport  : the controller side (drives req_ready, rsp_*)
// Signals:
//   req_valid/req_ready : request handshake
//   req_we              : 1 = write, 0 = read
//   req_conf            : word width, 00 = 32b, 01 = 16b, 10 = 8b, 11 = illegal
//   req_addr            : [ROW_BITS+1:2] row, [1:0] sub-word select
//   req_wdata           : right-aligned write data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : zero-extended read result
//   rsp_err             : illegal width requested
interface sram_access_ctrl_if #(
  parameter int ROW_BITS = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_conf;
  logic [ROW_BITS+1:0]   req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_conf, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_conf, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequencer for one access to an SRAM row: precharge, wordline (with the
// write drivers for writes), sense, then a held response.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   bus (slave)           : request/response handshake bus
//   row_addr              : row to the array decoder (0 outside PRE/ACT/SENSE)
//   pre_en/wl_en/wr_en/sae: precharge, wordline, write driver, sense-amp enables
//   mask_conf/mask_addr   : drive the 8-of-32 bitline-mask decoder
//   arr_wdata             : lane-replicated write data (0 outside ACT)
//   arr_rdata             : sensed row data, captured at the end of SENSE
// All outputs are registers; each state transition also loads the output
// values belonging to the state being entered.
module sram_access_ctrl #(
  parameter int ROW_BITS  = 5,  // row address width
  parameter int WL_CYCLES = 2   // wordline-active cycles per access (1..15)
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_access_ctrl_if.slave   bus,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                pre_en,
  output logic                wl_en,
  output logic                wr_en,
  output logic                sae,
  output logic [1:0]          mask_conf,
  output logic [1:0]          mask_addr,
  output logic [31:0]         arr_wdata,
  input  logic [31:0]         arr_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ACT   = 3'd2,
    SENSE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              state_reg;
  logic [3:0]          act_cnt_reg;

  // Request fields captured on acceptance, held until back in IDLE.
  logic [ROW_BITS-1:0] row_reg;
  logic [1:0]          conf_reg;
  logic [1:0]          sub_reg;
  logic                we_reg;
  logic [31:0]         wdata_reg;

  // Registered outputs.
  logic                req_ready_reg;
  logic                pre_en_reg;
  logic                wl_en_reg;
  logic                wr_en_reg;
  logic                sae_reg;
  logic [ROW_BITS-1:0] row_addr_reg;
  logic [1:0]          mask_conf_reg;
  logic [1:0]          mask_addr_reg;
  logic [31:0]         arr_wdata_reg;
  logic                rsp_valid_reg;
  logic [31:0]         rsp_rdata_reg;
  logic                rsp_err_reg;

  logic [31:0]         rep_wdata;

  // Sub-select bits the width does not use are forced to 0.
  function automatic logic [1:0] mask_sel(input logic [1:0] conf, input logic [1:0] sub);
    case (conf)
      2'b01:   return {1'b0, sub[0]};
      2'b10:   return sub;
      default: return 2'b00;
    endcase
  endfunction

  // Pick the addressed lane out of a full row word, zero-extended.
  function automatic logic [31:0] lane_extract(input logic [1:0] conf, input logic [1:0] sub,
                                               input logic [31:0] data);
    case (conf)
      2'b01:   return sub[0] ? {16'h0000, data[31:16]} : {16'h0000, data[15:0]};
      2'b10: begin
        case (sub)
          2'd0:    return {24'h000000, data[7:0]};
          2'd1:    return {24'h000000, data[15:8]};
          2'd2:    return {24'h000000, data[23:16]};
          default: return {24'h000000, data[31:24]};
        endcase
      end
      default: return data;
    endcase
  endfunction

  // Replicate the right-aligned write data into every lane so the bitline
  // mask alone decides which bits actually get written.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (conf_reg)
          2'b00:   rep_wdata[8*gi +: 8] = wdata_reg[8*gi +: 8];
          2'b01:   rep_wdata[8*gi +: 8] = wdata_reg[8*(gi%2) +: 8];
          default: rep_wdata[8*gi +: 8] = wdata_reg[7:0];
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      act_cnt_reg   <= 4'd0;
      row_reg       <= '0;
      conf_reg      <= 2'b00;
      sub_reg       <= 2'b00;
      we_reg        <= 1'b0;
      wdata_reg     <= 32'h0;
      req_ready_reg <= 1'b0;
      pre_en_reg    <= 1'b0;
      wl_en_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      sae_reg       <= 1'b0;
      row_addr_reg  <= '0;
      mask_conf_reg <= 2'b00;
      mask_addr_reg <= 2'b00;
      arr_wdata_reg <= 32'h0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // req_ready is a register, so it rises one cycle after reset
          // release or after a response completes.
          if (bus.req_valid && req_ready_reg) begin
            row_reg       <= bus.req_addr[ROW_BITS+1:2];
            conf_reg      <= bus.req_conf;
            sub_reg       <= bus.req_addr[1:0];
            we_reg        <= bus.req_we;
            wdata_reg     <= bus.req_wdata;
            req_ready_reg <= 1'b0;
            if (bus.req_conf == 2'b11) begin
              // Illegal width: answer straight away, never touch the array.
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 32'h0;
            end else begin
              state_reg     <= PRE;
              pre_en_reg    <= 1'b1;
              row_addr_reg  <= bus.req_addr[ROW_BITS+1:2];
              mask_conf_reg <= bus.req_conf;
              mask_addr_reg <= mask_sel(bus.req_conf, bus.req_addr[1:0]);
            end
          end else begin
            req_ready_reg <= 1'b1;
          end
        end

        PRE: begin
          state_reg     <= ACT;
          act_cnt_reg   <= 4'(WL_CYCLES);
          pre_en_reg    <= 1'b0;
          wl_en_reg     <= 1'b1;
          wr_en_reg     <= we_reg;
          arr_wdata_reg <= rep_wdata;
        end

        ACT: begin
          if (act_cnt_reg <= 4'd1) begin
            act_cnt_reg   <= 4'd0;
            wr_en_reg     <= 1'b0;
            arr_wdata_reg <= 32'h0;
            if (we_reg) begin
              state_reg     <= RESP;
              wl_en_reg     <= 1'b0;
              row_addr_reg  <= '0;
              mask_conf_reg <= 2'b00;
              mask_addr_reg <= 2'b00;
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= 32'h0;
              rsp_err_reg   <= 1'b0;
            end else begin
              // Wordline stays up through SENSE.
              state_reg <= SENSE;
              sae_reg   <= 1'b1;
            end
          end else begin
            act_cnt_reg <= act_cnt_reg - 4'd1;
          end
        end

        SENSE: begin
          state_reg     <= RESP;
          wl_en_reg     <= 1'b0;
          sae_reg       <= 1'b0;
          row_addr_reg  <= '0;
          mask_conf_reg <= 2'b00;
          mask_addr_reg <= 2'b00;
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= lane_extract(conf_reg, sub_reg, arr_rdata);
          rsp_err_reg   <= 1'b0;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign pre_en        = pre_en_reg;
  assign wl_en         = wl_en_reg;
  assign wr_en         = wr_en_reg;
  assign sae           = sae_reg;
  assign row_addr      = row_addr_reg;
  assign mask_conf     = mask_conf_reg;
  assign mask_addr     = mask_addr_reg;
  assign arr_wdata     = arr_wdata_reg;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl (ROW_BITS=5, WL_CYCLES=2).
// Inputs are driven and outputs sampled on the falling edge; "cycle N" is
// the cycle after the Nth rising edge counted from the accepting edge.
module tb_sram_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  row_addr;
  logic        pre_en, wl_en, wr_en, sae;
  logic [1:0]  mask_conf, mask_addr;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;

  sram_access_ctrl_if #(.ROW_BITS(5)) bus ();

  sram_access_ctrl #(.ROW_BITS(5), .WL_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .row_addr  (row_addr),
    .pre_en    (pre_en),
    .wl_en     (wl_en),
    .wr_en     (wr_en),
    .sae       (sae),
    .mask_conf (mask_conf),
    .mask_addr (mask_addr),
    .arr_wdata (arr_wdata),
    .arr_rdata (arr_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ctl = {req_ready, pre_en, wl_en, wr_en, sae, rsp_valid}
  task automatic chk_st(input string tag, input logic [5:0] ctl, input logic [4:0] row,
                        input logic [1:0] mc, input logic [1:0] ma, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err);
    chk({tag, " ctl"}, {26'h0, bus.req_ready, pre_en, wl_en, wr_en, sae, bus.rsp_valid},
        {26'h0, ctl});
    chk({tag, " row"}, {27'h0, row_addr}, {27'h0, row});
    chk({tag, " mconf"}, {30'h0, mask_conf}, {30'h0, mc});
    chk({tag, " maddr"}, {30'h0, mask_addr}, {30'h0, ma});
    chk({tag, " wdata"}, arr_wdata, wd);
    chk({tag, " rdata"}, bus.rsp_rdata, rd);
    chk({tag, " err"}, {31'h0, bus.rsp_err}, {31'h0, err});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one rising edge, then scramble the request inputs
  // (they must be ignored while req_ready is low). Returns in cycle 1.
  task automatic start_req(input logic we, input logic [1:0] conf, input logic [6:0] addr,
                           input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_conf  = conf;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_conf  = 2'b11;
    bus.req_addr  = 7'h7F;
    bus.req_wdata = 32'hFFFF_FFFF;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_conf  = 2'b00;
    bus.req_addr  = 7'h00;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    arr_rdata     = 32'h0;
    repeat (2) step();
    chk_st("reset", 6'b000000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_st("idle", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // 32-bit read, row 3
    arr_rdata = 32'hDEAD_BEEF;
    start_req(1'b0, 2'b00, 7'h0C, 32'h0);
    chk_st("rd32 c1", 6'b010000, 5'd3, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    step(); chk_st("rd32 c2", 6'b001000, 5'd3, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    step(); chk_st("rd32 c3", 6'b001000, 5'd3, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    step(); chk_st("rd32 c4", 6'b001010, 5'd3, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    step(); chk_st("rd32 c5", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    step(); chk_st("rd32 c6", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // 8-bit write, row 7, byte 2
    start_req(1'b1, 2'b10, 7'h1E, 32'h0000_00A5);
    chk_st("wr8 c1", 6'b010000, 5'd7, 2'd2, 2'd2, 32'h0, 32'h0, 1'b0);
    step(); chk_st("wr8 c2", 6'b001100, 5'd7, 2'd2, 2'd2, 32'hA5A5_A5A5, 32'h0, 1'b0);
    step(); chk_st("wr8 c3", 6'b001100, 5'd7, 2'd2, 2'd2, 32'hA5A5_A5A5, 32'h0, 1'b0);
    step(); chk_st("wr8 c4", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    step(); chk_st("wr8 c5", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // 16-bit write, upper half select ignored bit set: replication check
    start_req(1'b1, 2'b01, 7'h13, 32'h0000_5AC3);
    chk_st("wr16 c1", 6'b010000, 5'd4, 2'd1, 2'd1, 32'h0, 32'h0, 1'b0);
    step(); chk_st("wr16 c2", 6'b001100, 5'd4, 2'd1, 2'd1, 32'h5AC3_5AC3, 32'h0, 1'b0);
    repeat (3) step();
    chk_st("wr16 c5", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // 16-bit reads, sub 01 then sub 11 (bit 1 ignored)
    arr_rdata = 32'h1234_ABCD;
    start_req(1'b0, 2'b01, 7'h05, 32'h0);
    chk_st("rd16a c1", 6'b010000, 5'd1, 2'd1, 2'd1, 32'h0, 32'h0, 1'b0);
    repeat (4) step();
    chk_st("rd16a c5", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0000_1234, 1'b0);
    step();
    start_req(1'b0, 2'b01, 7'h07, 32'h0);
    chk_st("rd16b c1", 6'b010000, 5'd1, 2'd1, 2'd1, 32'h0, 32'h0, 1'b0);
    repeat (4) step();
    chk_st("rd16b c5", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0000_1234, 1'b0);
    step();

    // 8-bit read, byte 3, row 2
    start_req(1'b0, 2'b10, 7'h0B, 32'h0);
    chk_st("rd8 c1", 6'b010000, 5'd2, 2'd2, 2'd3, 32'h0, 32'h0, 1'b0);
    repeat (4) step();
    chk_st("rd8 c5", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0000_0012, 1'b0);
    step();

    // Illegal width: immediate error response, no array activity
    start_req(1'b0, 2'b11, 7'h0C, 32'h0);
    chk_st("ill c1", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b1);
    step(); chk_st("ill c2", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // Back-pressure on the response
    bus.rsp_ready = 1'b0;
    arr_rdata = 32'hCAFE_F00D;
    start_req(1'b0, 2'b00, 7'h24, 32'h0);
    repeat (4) step();
    arr_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk_st("bp hold", 6'b000001, 5'd0, 2'd0, 2'd0, 32'h0, 32'hCAFE_F00D, 1'b0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk_st("bp release", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // Reset during ACT drops the transaction
    arr_rdata = 32'hDEAD_BEEF;
    start_req(1'b0, 2'b00, 7'h0C, 32'h0);
    step();
    chk_st("rst act", 6'b001000, 5'd3, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    step();
    chk_st("rst hit", 6'b000000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_st("rst rel", 6'b100000, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0);

    // A fresh read after reset completes with the normal latency
    start_req(1'b0, 2'b00, 7'h0C, 32'h0);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("post-rst latency", 32'(lat), 32'd5);
    chk("post-rst rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
